// File: rtl/panel_input.sv
// rtl/panel_input.sv - front-panel input conditioning: synchronizers, debouncers, Go strobe

module panel_input_debounce #(
    parameter int W         = 1,
    parameter int DB_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sync_q,
    input  logic [W-1:0] sync_next,
    output logic [W-1:0] stable
);
    localparam int            CW       = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          advance;

    // Count only while the synchronized value differs from stable and has not moved
    // since the previous sample; any bounce drops the count back to zero.
    assign advance = (sync_q != stable) && (sync_next == sync_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= '0;
            cnt    <= '0;
        end else if (advance) begin
            if (cnt == CNT_LAST) begin
                stable <= sync_q;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end
endmodule

module panel_input #(
    parameter int DB_CYCLES     = 1000000,
    parameter int REPEAT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       btn_go_raw,
    input  logic       btn_clr_raw,
    input  logic [2:0] sw_show_raw,
    input  logic [1:0] sw_hz_raw,
    input  logic [3:0] sw_probe_raw,
    output logic       go_level,
    output logic       go_pulse,
    output logic       clr_req,
    output logic [2:0] show,
    output logic [1:0] hz,
    output logic [3:0] probe,
    output logic       sw_changed
);
    // A period of 1 would strobe every cycle; the shortest legal repeat is 2.
    localparam bit            REP_ON   = (REPEAT_CYCLES > 0);
    localparam int            REP_EFF  = (REPEAT_CYCLES < 2) ? 2 : REPEAT_CYCLES;
    localparam int            RW       = $clog2(REP_EFF);
    localparam logic [RW-1:0] REP_LAST = RW'(REP_EFF - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } go_state_t;

    logic [10:0]   raw_vec;
    logic [10:0]   sync1;
    logic [10:0]   sync2;
    logic [8:0]    sw_stable;
    logic [8:0]    sw_prev;
    go_state_t     state;
    go_state_t     state_next;
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_cnt_next;

    assign raw_vec = {btn_go_raw, btn_clr_raw, sw_show_raw, sw_hz_raw, sw_probe_raw};

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_vec;
            sync2 <= sync1;
        end
    end

    panel_input_debounce #(.W(1), .DB_CYCLES(DB_CYCLES)) u_go_db (
        .clk       (clk),
        .rst_n     (clr_n),
        .sync_q    (sync2[10]),
        .sync_next (sync1[10]),
        .stable    (go_level)
    );

    panel_input_debounce #(.W(1), .DB_CYCLES(DB_CYCLES)) u_clr_db (
        .clk       (clk),
        .rst_n     (clr_n),
        .sync_q    (sync2[9]),
        .sync_next (sync1[9]),
        .stable    (clr_req)
    );

    // The nine switch bits debounce as one word so show/hz/probe can never split.
    panel_input_debounce #(.W(9), .DB_CYCLES(DB_CYCLES)) u_sw_db (
        .clk       (clk),
        .rst_n     (clr_n),
        .sync_q    (sync2[8:0]),
        .sync_next (sync1[8:0]),
        .stable    (sw_stable)
    );

    assign {show, hz, probe} = sw_stable;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sw_prev    <= '0;
            sw_changed <= 1'b0;
        end else begin
            sw_prev    <= sw_stable;
            sw_changed <= (sw_stable != sw_prev);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state   <= IDLE;
            rep_cnt <= '0;
        end else begin
            state   <= state_next;
            rep_cnt <= rep_cnt_next;
        end
    end

    // go_pulse is decoded from registered state only, so it rises with go_level itself.
    always_comb begin
        state_next   = state;
        rep_cnt_next = rep_cnt;
        go_pulse     = 1'b0;
        case (state)
            IDLE: begin
                if (go_level) begin
                    go_pulse     = 1'b1;
                    state_next   = HELD;
                    rep_cnt_next = '0;
                end
            end
            HELD, REPEAT: begin
                if (!go_level) begin
                    state_next   = IDLE;
                    rep_cnt_next = '0;
                end else if (REP_ON) begin
                    if (rep_cnt == REP_LAST) begin
                        go_pulse     = 1'b1;
                        state_next   = REPEAT;
                        rep_cnt_next = '0;
                    end else begin
                        rep_cnt_next = rep_cnt + RW'(1);
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                rep_cnt_next = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_panel_input.sv
// tb/tb_panel_input.sv - self-checking bench for panel_input with a sample-window model

module tb_panel_input;
    localparam int DB  = 4;
    localparam int REP = 8;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       btn_go_raw = 1'b0;
    logic       btn_clr_raw = 1'b0;
    logic [2:0] sw_show_raw = '0;
    logic [1:0] sw_hz_raw = '0;
    logic [3:0] sw_probe_raw = '0;
    logic       go_level, go_pulse, clr_req, sw_changed;
    logic [2:0] show;
    logic [1:0] hz;
    logic [3:0] probe;

    always #5 clk = ~clk;

    panel_input #(.DB_CYCLES(DB), .REPEAT_CYCLES(REP)) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .btn_go_raw   (btn_go_raw),
        .btn_clr_raw  (btn_clr_raw),
        .sw_show_raw  (sw_show_raw),
        .sw_hz_raw    (sw_hz_raw),
        .sw_probe_raw (sw_probe_raw),
        .go_level     (go_level),
        .go_pulse     (go_pulse),
        .clr_req      (clr_req),
        .show         (show),
        .hz           (hz),
        .probe        (probe),
        .sw_changed   (sw_changed)
    );

    int errors = 0;
    int checks = 0;

    // Model: an output takes value v at edge k when the raw samples of edges
    // k-DB-1 .. k-1 all equal v (two sync stages plus DB stable cycles).
    logic [10:0] hist [DB+1];
    logic        m_go, m_clr, m_pulse, m_swchg, sw_load_prev;
    logic [8:0]  m_sw;
    int          hi_cnt;

    int ecnt, go_rise, go_fall, clr_rise, swchg_n;
    bit go_seen, clr_seen;
    int pulse_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i <= DB; i++) hist[i] = '0;
        m_go = 0; m_clr = 0; m_pulse = 0; m_swchg = 0; sw_load_prev = 0;
        m_sw = '0; hi_cnt = 0;
    endtask

    task automatic model_edge();
        logic [10:0] cur;
        bit go_ok, clr_ok, sw_ok, sw_load, prev_go;
        cur = {btn_go_raw, btn_clr_raw, sw_show_raw, sw_hz_raw, sw_probe_raw};
        go_ok = 1; clr_ok = 1; sw_ok = 1;
        for (int i = 1; i <= DB; i++) begin
            if (hist[i][10] != hist[0][10]) go_ok = 0;
            if (hist[i][9] != hist[0][9]) clr_ok = 0;
            if (hist[i][8:0] != hist[0][8:0]) sw_ok = 0;
        end
        prev_go = m_go;
        if (go_ok) m_go = hist[0][10];
        if (clr_ok) m_clr = hist[0][9];
        sw_load = sw_ok && (hist[0][8:0] != m_sw);
        if (sw_load) m_sw = hist[0][8:0];
        m_swchg = sw_load_prev;
        sw_load_prev = sw_load;
        for (int i = 0; i < DB; i++) hist[i] = hist[i+1];
        hist[DB] = cur;
        if (m_go) hi_cnt = prev_go ? hi_cnt + 1 : 0;
        m_pulse = m_go && ((hi_cnt % REP) == 0);
    endtask

    task automatic compare_all();
        check("go_level", go_level, m_go);
        check("go_pulse", go_pulse, m_pulse);
        check("clr_req", clr_req, m_clr);
        check("show", show, m_sw[8:6]);
        check("hz", hz, m_sw[5:4]);
        check("probe", probe, m_sw[3:0]);
        check("sw_changed", sw_changed, m_swchg);
    endtask

    task automatic start_scn();
        ecnt = 0; go_rise = 0; go_fall = 0; clr_rise = 0; swchg_n = 0;
        go_seen = 0; clr_seen = 0;
        pulse_q.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        ecnt++;
        @(negedge clk);
        compare_all();
        if (go_pulse) pulse_q.push_back(ecnt);
        if (go_level && !go_seen) begin go_seen = 1; go_rise = ecnt; end
        if (go_seen && !go_level && go_fall == 0) go_fall = ecnt;
        if (clr_req && !clr_seen) begin clr_seen = 1; clr_rise = ecnt; end
        if (sw_changed) swchg_n++;
    endtask

    int exp_p[4] = '{6, 14, 22, 30};

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        check("rst_go_level", go_level, 0);
        check("rst_go_pulse", go_pulse, 0);
        clr_n = 1'b1;

        // Clean press held, released after edge 27
        start_scn();
        btn_go_raw = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 28) btn_go_raw = 1'b0;
            tick();
        end
        check("hold_go_rise_edge", go_rise, 6);
        check("hold_pulse_count", pulse_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check("hold_pulse_edge", (i < pulse_q.size()) ? pulse_q[i] : -1, exp_p[i]);
        check("hold_go_fall_edge", go_fall, 33);

        // Short 3-cycle glitch must be rejected
        start_scn();
        btn_go_raw = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            if (i == 4) btn_go_raw = 1'b0;
            tick();
        end
        check("glitch_go_seen", go_seen, 0);
        check("glitch_pulses", pulse_q.size(), 0);

        // hz flips for 3 cycles then settles: one atomic update
        start_scn();
        sw_show_raw = 3'b100;
        for (int i = 1; i <= 14; i++) begin
            sw_hz_raw = (i == 2) ? 2'b10 : (i <= 3) ? 2'b01 : 2'b11;
            tick();
        end
        check("sw_changed_count", swchg_n, 1);
        check("sw_show_final", show, 4);
        check("sw_hz_final", hz, 3);

        // Probe changes mid-count: count restarts, single update
        start_scn();
        for (int i = 1; i <= 14; i++) begin
            sw_probe_raw = (i <= 3) ? 4'd5 : 4'd6;
            tick();
        end
        check("probe_changed_count", swchg_n, 1);
        check("probe_final", probe, 6);

        // Reset pulse between edges while Go is counting
        start_scn();
        btn_go_raw = 1'b1;
        repeat (3) tick();
        clr_n = 1'b0;
        #1;
        check("midrst_go_level", go_level, 0);
        check("midrst_show", show, 0);
        check("midrst_hz", hz, 0);
        check("midrst_probe", probe, 0);
        check("midrst_sw_changed", sw_changed, 0);
        model_reset();
        compare_all();
        #1;
        clr_n = 1'b1;
        start_scn();
        repeat (10) tick();
        check("postrst_go_rise_edge", go_rise, 6);
        check("postrst_pulse_count", pulse_q.size(), 1);
        btn_go_raw = 1'b0;
        repeat (10) tick();

        // Clr and Go rising together stay independent but aligned
        start_scn();
        btn_go_raw = 1'b1;
        btn_clr_raw = 1'b1;
        repeat (10) tick();
        check("both_clr_rise_edge", clr_rise, 6);
        check("both_go_rise_edge", go_rise, 6);
        btn_clr_raw = 1'b0;
        repeat (10) tick();
        check("clr_released", clr_req, 0);
        check("go_still_held", go_level, 1);
        btn_go_raw = 1'b0;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
